// File: rtl/cache_i_sa.sv
// Set-associative, read-only instruction cache with true-LRU replacement,
// single-cycle flush and hit/miss counters.
`timescale 1ns/1ps
module cache_i_sa #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 8,
  parameter int WAYS       = 2
) (
  input  logic                                  clk,
  input  logic                                  proc_reset_n,
  output logic                                  proc_stall,
  input  logic [ADDR_W-1:0]                     proc_addr,
  input  logic                                  proc_read,
  output logic [DATA_W-1:0]                     proc_rdata,
  input  logic                                  proc_write,
  input  logic [DATA_W-1:0]                     proc_wdata,
  output logic [ADDR_W-$clog2(LINE_WORDS)-1:0]  mem_addr,
  output logic                                  mem_read,
  input  logic [LINE_WORDS*DATA_W-1:0]          mem_rdata,
  output logic                                  mem_write,
  output logic [LINE_WORDS*DATA_W-1:0]          mem_wdata,
  input  logic                                  mem_ready,
  input  logic                                  flush,
  output logic [31:0]                           hit_cnt,
  output logic [31:0]                           miss_cnt
);
  localparam int OW     = $clog2(LINE_WORDS);
  localparam int OFW    = (OW > 0) ? OW : 1;
  localparam int SW     = $clog2(SETS);
  localparam int TW     = ADDR_W - SW - OW;
  localparam int LA     = ADDR_W - OW;
  localparam int MEM_DW = LINE_WORDS * DATA_W;
  localparam int AGW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FILL} state_t;
  typedef logic [WAYS-1:0][AGW-1:0] age_row_t;

  state_t              state_reg;
  logic [LA-1:0]       mem_addr_reg;
  logic [AGW-1:0]      victim_reg;
  logic                drop_reg;
  logic [31:0]         hit_cnt_reg;
  logic [31:0]         miss_cnt_reg;
  logic [WAYS-1:0]     valid_reg [SETS];
  age_row_t            age_reg   [SETS];

  logic [TW-1:0]       req_tag;
  logic [SW-1:0]       req_idx;
  logic [OFW-1:0]      req_off;
  logic [SW-1:0]       fill_idx;
  logic [TW-1:0]       fill_tag;
  logic                fill_we;
  logic [WAYS-1:0]     way_hit;
  logic [WAYS-1:0][MEM_DW-1:0] way_line;
  logic                hit_any;
  logic [AGW-1:0]      hit_way;
  logic [AGW-1:0]      victim_next;
  logic                found;
  logic                lookup_hit;
  logic                lookup_miss;
  logic                unused_ok;

  assign req_tag  = proc_addr[ADDR_W-1 -: TW];
  assign req_idx  = proc_addr[OW +: SW];
  assign fill_idx = mem_addr_reg[SW-1:0];
  assign fill_tag = mem_addr_reg[LA-1 -: TW];
  assign fill_we  = (state_reg == S_WAIT) && mem_ready && !drop_reg && !flush;

  generate
    if (OW > 0) begin : g_off
      assign req_off = proc_addr[OFW-1:0];
    end else begin : g_no_off
      assign req_off = '0;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TW-1:0]     tag_mem  [SETS];
      logic [MEM_DW-1:0] data_mem [SETS];
      always_ff @(posedge clk) begin
        if (fill_we && (victim_reg == AGW'(gi))) begin
          tag_mem[fill_idx]  <= fill_tag;
          data_mem[fill_idx] <= mem_rdata;
        end
      end
      assign way_hit[gi]  = valid_reg[req_idx][gi] && (tag_mem[req_idx] == req_tag);
      assign way_line[gi] = data_mem[req_idx];
    end
  endgenerate

  // Victim: first invalid way, otherwise the least recently used one.
  always_comb begin
    hit_any     = 1'b0;
    hit_way     = '0;
    found       = 1'b0;
    victim_next = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_any = 1'b1;
        hit_way = AGW'(w);
      end
      if (!found && !valid_reg[req_idx][w]) begin
        found       = 1'b1;
        victim_next = AGW'(w);
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_reg[req_idx][w] == AGW'(WAYS-1)) victim_next = AGW'(w);
      end
    end
  end

  assign lookup_hit  = (state_reg == S_IDLE) && proc_read && hit_any;
  assign lookup_miss = (state_reg == S_IDLE) && proc_read && !hit_any;
  assign proc_stall  = (state_reg != S_IDLE) || lookup_miss;
  assign proc_rdata  = lookup_hit ? way_line[hit_way][req_off*DATA_W +: DATA_W] : '0;
  assign mem_read    = (state_reg == S_WAIT);
  assign mem_addr    = mem_addr_reg;
  assign mem_write   = 1'b0;
  assign mem_wdata   = '0;
  assign hit_cnt     = hit_cnt_reg;
  assign miss_cnt    = miss_cnt_reg;
  assign unused_ok   = ^{proc_write, proc_wdata};

  function automatic age_row_t lru_touch(input age_row_t row, input logic [AGW-1:0] w);
    age_row_t r;
    r = row;
    for (int j = 0; j < WAYS; j++) begin
      if (row[j] < row[w]) r[j] = row[j] + AGW'(1);
    end
    r[w] = '0;
    return r;
  endfunction

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_reg    <= S_IDLE;
      mem_addr_reg <= '0;
      victim_reg   <= '0;
      drop_reg     <= 1'b0;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_reg[s][w] <= AGW'(w);
      end
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (lookup_hit) begin
            hit_cnt_reg      <= hit_cnt_reg + 32'd1;
            age_reg[req_idx] <= lru_touch(age_reg[req_idx], hit_way);
          end
          if (lookup_miss && !flush) begin
            state_reg    <= S_WAIT;
            mem_addr_reg <= proc_addr[ADDR_W-1:OW];
            victim_reg   <= victim_next;
            miss_cnt_reg <= miss_cnt_reg + 32'd1;
          end
        end
        S_WAIT: begin
          if (flush) drop_reg <= 1'b1;
          if (mem_ready) begin
            drop_reg <= 1'b0;
            if (drop_reg || flush) begin
              state_reg <= S_IDLE;
            end else begin
              state_reg                       <= S_FILL;
              valid_reg[fill_idx][victim_reg] <= 1'b1;
            end
          end
        end
        S_FILL: begin
          age_reg[fill_idx] <= lru_touch(age_reg[fill_idx], victim_reg);
          state_reg         <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
      // Flush takes priority over any valid bit set in the same cycle.
      if (flush) begin
        for (int s = 0; s < SETS; s++) valid_reg[s] <= '0;
      end
    end
  end
endmodule
